// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating counters, execute-stage training,
// same-cycle mispredict/redirect and saturating resolved/mispredict perf counters.
module branch_predictor #(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 6,
  parameter int CTR_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              update_valid,
  input  logic [ADDR_W-1:0] update_pc,
  input  logic              update_taken,
  input  logic [ADDR_W-1:0] update_target,
  input  logic              update_pred_taken,
  input  logic [ADDR_W-1:0] update_pred_target,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       branch_count,
  output logic [31:0]       mispredict_count
);

  localparam int TAG_W   = ADDR_W - INDEX_W - 2;
  localparam int ENTRIES = 1 << INDEX_W;
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1);

  logic              r_valid  [ENTRIES];
  logic [TAG_W-1:0]  r_tag    [ENTRIES];
  logic [ADDR_W-1:0] r_target [ENTRIES];
  logic [CTR_W-1:0]  r_ctr    [ENTRIES];
  logic [31:0]       r_branchCount;
  logic [31:0]       r_mispredictCount;

  logic [INDEX_W-1:0] w_lkIdx;
  logic [TAG_W-1:0]   w_lkTag;
  logic               w_lkHit;
  logic [INDEX_W-1:0] w_upIdx;
  logic [TAG_W-1:0]   w_upTag;
  logic               w_upHit;
  logic               w_update;
  logic               w_unusedBits;

  assign w_lkIdx  = lookup_pc[INDEX_W+1:2];
  assign w_lkTag  = lookup_pc[ADDR_W-1:INDEX_W+2];
  assign w_lkHit  = r_valid[w_lkIdx] && (r_tag[w_lkIdx] == w_lkTag);
  assign w_upIdx  = update_pc[INDEX_W+1:2];
  assign w_upTag  = update_pc[ADDR_W-1:INDEX_W+2];
  assign w_upHit  = r_valid[w_upIdx] && (r_tag[w_upIdx] == w_upTag);
  // An update arriving while reset is held is dropped everywhere.
  assign w_update = update_valid && !reset;
  assign w_unusedBits = ^{lookup_pc[1:0], update_pc[1:0]};

  always_comb begin
    pred_hit    = 1'b0;
    pred_taken  = 1'b0;
    pred_target = lookup_pc + ADDR_W'(4);
    if (!reset) begin
      pred_hit   = w_lkHit;
      pred_taken = w_lkHit && r_ctr[w_lkIdx][CTR_W-1];
      if (pred_taken) begin
        pred_target = r_target[w_lkIdx];
      end
    end
  end

  always_comb begin
    mispredict  = 1'b0;
    redirect_pc = '0;
    if (w_update) begin
      mispredict  = (update_taken != update_pred_taken) ||
                    (update_taken && (update_target != update_pred_target));
      redirect_pc = update_taken ? update_target : update_pc + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= CTR_WNT;
      end
    end else if (update_valid) begin
      if (w_upHit) begin
        if (update_taken) begin
          if (r_ctr[w_upIdx] != CTR_MAX) begin
            r_ctr[w_upIdx] <= r_ctr[w_upIdx] + CTR_W'(1);
          end
          r_target[w_upIdx] <= update_target;
        end else if (r_ctr[w_upIdx] != '0) begin
          r_ctr[w_upIdx] <= r_ctr[w_upIdx] - CTR_W'(1);
        end
      end else if (update_taken) begin
        // Allocation evicts whatever alias occupied this index.
        r_valid[w_upIdx]  <= 1'b1;
        r_tag[w_upIdx]    <= w_upTag;
        r_target[w_upIdx] <= update_target;
        r_ctr[w_upIdx]    <= CTR_WT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_branchCount     <= '0;
      r_mispredictCount <= '0;
    end else if (update_valid) begin
      if (r_branchCount != '1) begin
        r_branchCount <= r_branchCount + 32'd1;
      end
      if (mispredict && (r_mispredictCount != '1)) begin
        r_mispredictCount <= r_mispredictCount + 32'd1;
      end
    end
  end

  assign branch_count     = r_branchCount;
  assign mispredict_count = r_mispredictCount;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor: expectations are queued as each
// cycle's stimulus is driven and compared at the following falling edge.
module tb_branch_predictor;

  logic        clk;
  logic        reset;
  logic [31:0] lookup_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        update_pred_taken;
  logic [31:0] update_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  branch_predictor dut (
    .clk                (clk),
    .reset              (reset),
    .lookup_pc          (lookup_pc),
    .pred_hit           (pred_hit),
    .pred_taken         (pred_taken),
    .pred_target        (pred_target),
    .update_valid       (update_valid),
    .update_pc          (update_pc),
    .update_taken       (update_taken),
    .update_target      (update_target),
    .update_pred_taken  (update_pred_taken),
    .update_pred_target (update_pred_target),
    .mispredict         (mispredict),
    .redirect_pc        (redirect_pc),
    .branch_count       (branch_count),
    .mispredict_count   (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int SEL_HIT    = 0;
  localparam int SEL_TAKEN  = 1;
  localparam int SEL_TARGET = 2;
  localparam int SEL_MISP   = 3;
  localparam int SEL_REDIR  = 4;
  localparam int SEL_BCNT   = 5;
  localparam int SEL_MCNT   = 6;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sbQ[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] getObs(int sel);
    case (sel)
      SEL_HIT:    return {31'b0, pred_hit};
      SEL_TAKEN:  return {31'b0, pred_taken};
      SEL_TARGET: return pred_target;
      SEL_MISP:   return {31'b0, mispredict};
      SEL_REDIR:  return redirect_pc;
      SEL_BCNT:   return branch_count;
      SEL_MCNT:   return mispredict_count;
      default:    return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expectVal(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sbQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [31:0] lk, input logic uv,
                               input logic [31:0] upc, input logic ut,
                               input logic [31:0] utgt, input logic upt,
                               input logic [31:0] uptgt);
    lookup_pc          = lk;
    update_valid       = uv;
    update_pc          = upc;
    update_taken       = ut;
    update_target      = utgt;
    update_pred_taken  = upt;
    update_pred_target = uptgt;
  endtask

  task automatic lookupOnly(input logic [31:0] lk);
    applyStimulus(lk, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Compare every queued expectation mid-cycle, then step to just after the next edge.
  task automatic checkOutput();
    exp_t        e;
    logic [31:0] obs;
    @(negedge clk);
    while (sbQ.size() > 0) begin
      e   = sbQ.pop_front();
      obs = getObs(e.sel);
      checks++;
      assert (obs === e.exp)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    lookupOnly(32'h0040_0010);
    @(posedge clk);
    #1;

    // Update offered during reset must be ignored and outputs held quiet.
    applyStimulus(32'h0040_0010, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0014);
    expectVal("rst_hit", SEL_HIT, 32'd0);
    expectVal("rst_taken", SEL_TAKEN, 32'd0);
    expectVal("rst_target", SEL_TARGET, 32'h0040_0014);
    expectVal("rst_misp", SEL_MISP, 32'd0);
    expectVal("rst_redir", SEL_REDIR, 32'd0);
    checkOutput();
    reset = 1'b0;

    lookupOnly(32'h0040_0010);
    expectVal("post_rst_hit", SEL_HIT, 32'd0);
    expectVal("post_rst_target", SEL_TARGET, 32'h0040_0014);
    expectVal("post_rst_bcnt", SEL_BCNT, 32'd0);
    expectVal("post_rst_mcnt", SEL_MCNT, 32'd0);
    checkOutput();

    applyStimulus(32'h0040_0010, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0014);
    expectVal("alloc_misp", SEL_MISP, 32'd1);
    expectVal("alloc_redir", SEL_REDIR, 32'h0040_0100);
    expectVal("alloc_nobypass_hit", SEL_HIT, 32'd0);
    checkOutput();

    lookupOnly(32'h0040_0010);
    expectVal("alloc_hit", SEL_HIT, 32'd1);
    expectVal("alloc_taken", SEL_TAKEN, 32'd1);
    expectVal("alloc_target", SEL_TARGET, 32'h0040_0100);
    expectVal("alloc_bcnt", SEL_BCNT, 32'd1);
    expectVal("alloc_mcnt", SEL_MCNT, 32'd1);
    checkOutput();

    for (int k = 0; k < 3; k++) begin
      applyStimulus(32'h0040_0010, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b1, 32'h0040_0100);
      expectVal("sat_misp", SEL_MISP, 32'd0);
      expectVal("sat_redir", SEL_REDIR, 32'h0040_0100);
      checkOutput();
    end

    // Counter at 3: two not-taken resolutions leave it weakly not-taken.
    applyStimulus(32'h0040_0010, 1'b1, 32'h0040_0010, 1'b0, 32'h0040_0100, 1'b1, 32'h0040_0100);
    expectVal("nt1_misp", SEL_MISP, 32'd1);
    expectVal("nt1_redir", SEL_REDIR, 32'h0040_0014);
    expectVal("nt1_taken", SEL_TAKEN, 32'd1);
    checkOutput();
    applyStimulus(32'h0040_0010, 1'b1, 32'h0040_0010, 1'b0, 32'h0040_0100, 1'b1, 32'h0040_0100);
    expectVal("nt2_misp", SEL_MISP, 32'd1);
    expectVal("nt2_taken", SEL_TAKEN, 32'd1);
    checkOutput();

    lookupOnly(32'h0040_0010);
    expectVal("wnt_hit", SEL_HIT, 32'd1);
    expectVal("wnt_taken", SEL_TAKEN, 32'd0);
    expectVal("wnt_target", SEL_TARGET, 32'h0040_0014);
    expectVal("wnt_bcnt", SEL_BCNT, 32'd6);
    expectVal("wnt_mcnt", SEL_MCNT, 32'd3);
    checkOutput();

    applyStimulus(32'h0040_0010, 1'b1, 32'h0040_0010, 1'b0, 32'h0040_0100, 1'b0, 32'h1234_5678);
    expectVal("nt_ok_misp", SEL_MISP, 32'd0);
    expectVal("nt_ok_redir", SEL_REDIR, 32'h0040_0014);
    checkOutput();

    applyStimulus(32'h0040_0010, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b1, 32'h0040_0104);
    expectVal("tgt_misp", SEL_MISP, 32'd1);
    expectVal("tgt_redir", SEL_REDIR, 32'h0040_0100);
    expectVal("tgt_taken", SEL_TAKEN, 32'd0);
    checkOutput();

    lookupOnly(32'h0040_0010);
    expectVal("ctr1_hit", SEL_HIT, 32'd1);
    expectVal("ctr1_taken", SEL_TAKEN, 32'd0);
    expectVal("ctr1_bcnt", SEL_BCNT, 32'd8);
    expectVal("ctr1_mcnt", SEL_MCNT, 32'd4);
    checkOutput();

    applyStimulus(32'h0040_0020, 1'b1, 32'h0040_0020, 1'b0, 32'h0040_0500, 1'b0, 32'h0040_0024);
    expectVal("miss_nt_misp", SEL_MISP, 32'd0);
    expectVal("miss_nt_redir", SEL_REDIR, 32'h0040_0024);
    checkOutput();
    lookupOnly(32'h0040_0020);
    expectVal("miss_nt_hit", SEL_HIT, 32'd0);
    expectVal("miss_nt_bcnt", SEL_BCNT, 32'd9);
    checkOutput();

    // Same index, different tag: the new branch evicts the old entry.
    applyStimulus(32'h0040_0010, 1'b1, 32'h0040_0110, 1'b1, 32'h0040_0200, 1'b0, 32'h0040_0114);
    expectVal("alias_misp", SEL_MISP, 32'd1);
    expectVal("alias_redir", SEL_REDIR, 32'h0040_0200);
    expectVal("alias_old_hit", SEL_HIT, 32'd1);
    checkOutput();
    lookupOnly(32'h0040_0010);
    expectVal("alias_evicted_hit", SEL_HIT, 32'd0);
    expectVal("alias_evicted_target", SEL_TARGET, 32'h0040_0014);
    checkOutput();
    lookupOnly(32'h0040_0110);
    expectVal("alias_new_hit", SEL_HIT, 32'd1);
    expectVal("alias_new_taken", SEL_TAKEN, 32'd1);
    expectVal("alias_new_target", SEL_TARGET, 32'h0040_0200);
    expectVal("alias_bcnt", SEL_BCNT, 32'd10);
    expectVal("alias_mcnt", SEL_MCNT, 32'd5);
    checkOutput();

    lookupOnly(32'hFFFF_FFFC);
    expectVal("wrap_target", SEL_TARGET, 32'h0000_0000);
    checkOutput();

    reset = 1'b1;
    applyStimulus(32'h0040_0110, 1'b1, 32'h0040_0300, 1'b1, 32'h0040_0700, 1'b0, 32'h0040_0304);
    expectVal("rst2_hit", SEL_HIT, 32'd0);
    expectVal("rst2_misp", SEL_MISP, 32'd0);
    checkOutput();
    reset = 1'b0;

    lookupOnly(32'h0040_0300);
    expectVal("rst2_dropped_hit", SEL_HIT, 32'd0);
    expectVal("rst2_bcnt", SEL_BCNT, 32'd0);
    expectVal("rst2_mcnt", SEL_MCNT, 32'd0);
    checkOutput();
    lookupOnly(32'h0040_0110);
    expectVal("rst2_alias_hit", SEL_HIT, 32'd0);
    checkOutput();
    lookupOnly(32'h0040_0010);
    expectVal("rst2_orig_hit", SEL_HIT, 32'd0);
    checkOutput();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
